// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler sharing one resource among 2**IDX_W requesters.
// Grants are held while the winner keeps requesting, bounded by MAX_HOLD cycles.
module rr_grant_scheduler #(
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [2**IDX_W-1:0]   req,
    output logic [2**IDX_W-1:0]   grant,
    output logic [IDX_W-1:0]      grant_idx,
    output logic                  grant_valid,
    output logic                  timeout
);

    localparam int unsigned N = 2**IDX_W;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RELEASE
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic [N-1:0]       r_grant;
    logic [IDX_W-1:0]   r_grant_idx;
    logic               r_grant_valid;
    logic               r_timeout;

    state_t             w_state_nxt;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [N-1:0]       w_grant_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               w_valid_nxt;
    logic               w_timeout_nxt;

    logic               w_win_found;
    logic [IDX_W-1:0]   w_win_idx;
    logic [IDX_W-1:0]   w_cand;

    // Scan from ptr upward; the index addition wraps modulo N by width.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_cand = r_ptr + IDX_W'(k);
            if (!w_win_found && req[w_cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand;
            end
        end
        if (!en) begin
            w_win_found = 1'b0;
            w_win_idx   = '0;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_hold_cnt;
        w_grant_nxt   = r_grant;
        w_idx_nxt     = r_grant_idx;
        w_valid_nxt   = r_grant_valid;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE, S_RELEASE: begin
                w_cnt_nxt = '0;
                if (w_win_found) begin
                    w_state_nxt = S_GRANT;
                    w_idx_nxt   = w_win_idx;
                    w_grant_nxt = ONE << w_win_idx;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                    w_grant_nxt = '0;
                    w_valid_nxt = 1'b0;
                end
            end
            S_GRANT: begin
                w_cnt_nxt = r_hold_cnt + 1'b1;
                // A requester drop takes precedence over the hold limit.
                if (!req[r_grant_idx] ||
                    ((MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST))) begin
                    w_state_nxt   = S_RELEASE;
                    w_ptr_nxt     = r_grant_idx + 1'b1;
                    w_grant_nxt   = '0;
                    w_idx_nxt     = '0;
                    w_valid_nxt   = 1'b0;
                    w_timeout_nxt = req[r_grant_idx];
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_idx_nxt   = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_hold_cnt    <= '0;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_hold_cnt    <= w_cnt_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_idx   <= w_idx_nxt;
            r_grant_valid <= w_valid_nxt;
            r_timeout     <= w_timeout_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;

endmodule

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
- Round-robin scheduler that shares one resource between 8 requesters.
- Registered state machine picks one requester, holds its grant while its request stays high (bounded by MAX_HOLD), then rotates priority.
- Drives the one-hot select bus (3-bit index decoded to 8 lines) used to steer the shared resource, plus the encoded index and a valid flag.

Parameters:
- IDX_W, 3: index width; requester count N = 2**IDX_W = 8.
- MAX_HOLD, 16: maximum consecutive grant cycles per tenure; 0 = unlimited.
- CNT_W, 5: hold counter width; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  arbitration enable; low blocks new grants, existing tenure continues.
- req  input  8  request lines, bit i = requester i; level-sensitive.
- grant  output  8  registered one-hot grant; all zero when nothing is granted.
- grant_idx  output  3  registered encoded winner; valid only when grant_valid=1.
- grant_valid  output  1  registered; 1 iff grant is non-zero.
- timeout  output  1  registered one-cycle pulse when a tenure is ended by MAX_HOLD.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - grant=8'h00, grant_idx=0, grant_valid=0, timeout=0.
  - priority pointer ptr=0, hold_cnt=0, state=IDLE.
  - Reset overrides every other condition, including mid-tenure: grant drops at that edge.
- States: IDLE, GRANT, RELEASE.
- Arbitration function, evaluated combinationally in IDLE and RELEASE:
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, ..., wrapping modulo 8 (7 -> 0).
  - No winner if req=0 or en=0.
- IDLE:
  - Winner found -> GRANT next edge: grant_idx=winner, grant = one-hot decode of winner, grant_valid=1, hold_cnt=0.
  - Otherwise stay in IDLE; outputs at reset values.
  - Latency: req sampled high at edge k -> grant visible after edge k (one clock).
- GRANT:
  - hold_cnt increments by 1 each cycle.
  - req[grant_idx]=0 -> RELEASE, timeout=0.
  - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 -> RELEASE, timeout=1. Grant is therefore high for exactly MAX_HOLD cycles.
  - Both conditions in the same cycle -> requester drop wins; timeout=0.
  - On entry to RELEASE: ptr = grant_idx+1 mod 8, grant=0, grant_valid=0.
  - Other requesters' req changes have no effect during GRANT.
  - en going low does not end the tenure.
- RELEASE: exactly one cycle, all grant outputs zero.
  - Arbitrates with the updated ptr.
  - Winner -> GRANT (same update as from IDLE); else -> IDLE.
  - timeout returns to 0 after its single cycle.
  - Guaranteed gap: at least one cycle of grant=0 between any two tenures, including back-to-back re-grant of the same requester.
- Fairness:
  - Requester that just held the grant has lowest priority next arbitration.
  - Any continuously requesting requester is granted within 7 tenures.
- Invariants: grant is zero or one-hot; grant == decode(grant_idx) when grant_valid=1; timeout=1 only while grant_valid=0.

Test Plan:
- Reset then req=8'h00 for 10 cycles -> grant=0, grant_valid=0, timeout=0 throughout.
- req=8'b0000_0100 set at edge k, dropped after 3 grant cycles -> grant=8'h04, grant_idx=2 after edge k for 3 cycles, then 1 RELEASE cycle of zeros, ptr=3.
- req=8'hFF held, MAX_HOLD=16 -> grants 0,1,...,7,0 in order; each 16 cycles long, 1 zero cycle between tenures, timeout pulsed after each tenure.
- ptr=6 (after granting 5), req=8'b0100_0001 -> idx 6 wins; after release, idx 0 wins (wrap).
- Req drop on the same cycle hold_cnt==15 -> RELEASE with timeout=0.
- rst_n=0 mid-tenure (idx 3 granted) -> next edge grant=0, ptr=0; with req=8'h09 after reset, idx 0 granted first.
- en=0 with req=8'h10 -> no grant. en=0 during an active tenure -> tenure continues until req drop; no new grant follows while en=0.
